// File: rtl/mips_register_scanner.sv
// mips_register_scanner: sweeps the register file through both read ports,
// two registers per pass, and streams every word out on a valid/ready port
// in ascending register order.
// Optional feature macro: SCAN_CHECKSUM_EN adds the checksum_o port, the
// running XOR of every word accepted by the consumer.
module mips_register_scanner #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] read_reg_1_o,
    output logic [ADDR_WIDTH-1:0] read_reg_2_o,
    input  logic [DATA_WIDTH-1:0] read_data_1_i,
    input  logic [DATA_WIDTH-1:0] read_data_2_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH-1:0] out_index_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef SCAN_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum_o
`endif
);

    // Pair counter is one bit narrower than a register index: index = {p, lsb}.
    localparam int PW = ADDR_WIDTH - 1;
    localparam logic [PW-1:0] LAST_PAIR = PW'(NUM_REGS / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_SEND_A = 3'd2,
        ST_SEND_B = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                  state_q;
    logic [PW-1:0]           p_q;
    logic [DATA_WIDTH-1:0]   buf1_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [ADDR_WIDTH-1:0]   out_index_q;
    logic                    busy_q;
    logic                    done_q;
    logic [ADDR_WIDTH-1:0]   rr1_q;
    logic [ADDR_WIDTH-1:0]   rr2_q;

    logic [PW-1:0]           p_d;
    logic [ADDR_WIDTH-1:0]   next_rr1_d;
    logic [ADDR_WIDTH-1:0]   next_rr2_d;
    logic                    handshake_s;
    logic                    start_accept_s;
    logic                    abort_s;

    // Next pair addresses and handshake/control qualifiers.
    always_comb begin
        p_d            = p_q + PW'(1);
        next_rr1_d     = {p_d, 1'b0};
        next_rr2_d     = {p_d, 1'b1};
        handshake_s    = out_valid_q & out_ready_i;
        start_accept_s = (state_q == ST_IDLE) & start_i & ~abort_i;
        abort_s        = abort_i & (state_q != ST_IDLE);
    end

    // Sweep FSM: all stream, status and read-address outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            p_q         <= {PW{1'b0}};
            buf1_q      <= {DATA_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_WIDTH{1'b0}};
            out_index_q <= {ADDR_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rr1_q       <= {ADDR_WIDTH{1'b0}};
            rr2_q       <= ADDR_WIDTH'(1);
        end else if (abort_s) begin
            // Abort beats any coincident handshake and never pulses done.
            state_q     <= ST_IDLE;
            p_q         <= {PW{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rr1_q       <= {ADDR_WIDTH{1'b0}};
            rr2_q       <= ADDR_WIDTH'(1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_accept_s) begin
                        state_q <= ST_READ;
                        p_q     <= {PW{1'b0}};
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    // Register contents are captured only in this cycle.
                    out_data_q  <= read_data_1_i;
                    buf1_q      <= read_data_2_i;
                    out_index_q <= {p_q, 1'b0};
                    out_valid_q <= 1'b1;
                    state_q     <= ST_SEND_A;
                end
                ST_SEND_A: begin
                    if (handshake_s) begin
                        out_data_q  <= buf1_q;
                        out_index_q <= {p_q, 1'b1};
                        state_q     <= ST_SEND_B;
                    end else begin
                        state_q     <= ST_SEND_A;
                    end
                end
                ST_SEND_B: begin
                    if (handshake_s) begin
                        out_valid_q <= 1'b0;
                        if (p_q == LAST_PAIR) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            p_q     <= p_d;
                            rr1_q   <= next_rr1_d;
                            rr2_q   <= next_rr2_d;
                            state_q <= ST_READ;
                        end
                    end else begin
                        state_q <= ST_SEND_B;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    p_q     <= {PW{1'b0}};
                    rr1_q   <= {ADDR_WIDTH{1'b0}};
                    rr2_q   <= ADDR_WIDTH'(1);
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    // Running XOR of accepted words; cleared when a sweep starts, kept on abort.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            checksum_q <= {DATA_WIDTH{1'b0}};
        end else if (start_accept_s) begin
            checksum_q <= {DATA_WIDTH{1'b0}};
        end else if (handshake_s && !abort_s) begin
            checksum_q <= checksum_q ^ out_data_q;
        end else begin
            checksum_q <= checksum_q;
        end
    end

    assign checksum_o = checksum_q;
`else
    // No checksum logic in this build.
`endif

    assign read_reg_1_o = rr1_q;
    assign read_reg_2_o = rr2_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_index_o  = out_index_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_mips_register_scanner.sv
// Testbench for mips_register_scanner: table of sweep scenarios plus
// hand-written abort / reset / held-start sequences, checked against a
// word-queue reference model of the register file dump.
module tb_mips_register_scanner;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        busy;
    logic        done;
`ifdef SCAN_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] regs [0:31];

    int n_checks = 0;
    int n_errors = 0;

    assign read_data_1 = regs[read_reg_1];
    assign read_data_2 = regs[read_reg_2];

    mips_register_scanner #(.NUM_REGS(32), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .abort_i       (abort),
        .read_reg_1_o  (read_reg_1),
        .read_reg_2_o  (read_reg_2),
        .read_data_1_i (read_data_1),
        .read_data_2_i (read_data_2),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_index_o   (out_index),
        .busy_o        (busy),
        .done_o        (done)
`ifdef SCAN_CHECKSUM_EN
        ,
        .checksum_o    (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] ready_mask;   // out_ready pattern, cycled one bit per clock
        bit         rnd_ready;    // use random out_ready instead of the mask
        int         data_mode;    // 0: i*0x01010101, 1: random, 2: checksum vector
        int         exp_words;    // words the sweep must deliver
        int         exp_base;     // done cycle after start with no stalls
    } vec_t;

    vec_t vecs [5];

    task automatic fill_regs(input int mode);
        for (int i = 0; i < 32; i++) begin
            case (mode)
                0:       regs[i] = i * 32'h01010101;
                1:       regs[i] = $urandom;
                default: regs[i] = (i == 2) ? 32'h0000FFFF : 32'hE001C000;
            endcase
        end
    endtask

    // One full sweep: start at the next edge N, then monitor every cycle.
    task automatic run_sweep(input logic [3:0] mask, input bit rnd, input int mode,
                             input bit hold, input int exp_words, input int exp_base);
        logic [31:0] exp_d[$];
        int          exp_i[$];
        int          c, stalls, words, done_c;
        bit          prev_stall;
        logic [31:0] prev_d;
        logic [4:0]  prev_i;
        logic [31:0] xsum;
        fill_regs(mode);
        for (int i = 0; i < 32; i++) begin
            exp_d.push_back(regs[i]);
            exp_i.push_back(i);
        end
        c = 0; stalls = 0; words = 0; done_c = 0; prev_stall = 1'b0;
        prev_d = 32'd0; prev_i = 5'd0; xsum = 32'd0;
        @(negedge clk);
        start = 1'b1;
        while (c < 3000 && done_c == 0) begin
            @(negedge clk);
            c++;
            if (!hold) start = 1'b0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : mask[c % 4];
            check("busy_in_sweep", 64'(busy), 64'd1);
            if (prev_stall) begin
                check("stall_valid_held", 64'(out_valid), 64'd1);
                check("stall_data_held", 64'(out_data), 64'(prev_d));
                check("stall_index_held", 64'(out_index), 64'(prev_i));
            end
            prev_stall = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_d.size() == 0) begin
                        check("extra_word", 64'(out_index), 64'd99);
                    end else begin
                        check("word_index", 64'(out_index), 64'(exp_i[0]));
                        check("word_data", 64'(out_data), 64'(exp_d[0]));
                        xsum ^= exp_d[0];
                        void'(exp_d.pop_front());
                        void'(exp_i.pop_front());
                        words++;
                    end
                end else begin
                    stalls++;
                    prev_stall = 1'b1;
                    prev_d = out_data;
                    prev_i = out_index;
                end
            end
            if (done) begin
                done_c = c;
                check("done_cycle", 64'(done_c), 64'(exp_base + stalls));
                check("word_count", 64'(words), 64'(exp_words));
`ifdef SCAN_CHECKSUM_EN
                check("checksum", 64'(checksum), 64'(xsum));
                if (mode == 2) check("checksum_vec", 64'(checksum), 64'h00000000E0013FFF);
`endif
            end
        end
        if (done_c == 0) check("sweep_timeout", 64'(c), 64'(exp_base));
    endtask

    initial begin
        int cnt_v, cnt_d, n;
        vecs[0] = '{4'b1111, 1'b0, 0, 32, 49};
        vecs[1] = '{4'b1001, 1'b0, 0, 32, 49};
        vecs[2] = '{4'b0000, 1'b1, 1, 32, 49};
        vecs[3] = '{4'b0101, 1'b0, 1, 32, 49};
        vecs[4] = '{4'b1111, 1'b0, 2, 32, 49};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        fill_regs(0);
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_index", 64'(out_index), 64'd0);
        check("rst_rr1", 64'(read_reg_1), 64'd0);
        check("rst_rr2", 64'(read_reg_2), 64'd1);
`ifdef SCAN_CHECKSUM_EN
        check("rst_checksum", 64'(checksum), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Table of sweeps under different ready patterns and register contents.
        for (int v = 0; v < 5; v++) begin
            run_sweep(vecs[v].ready_mask, vecs[v].rnd_ready, vecs[v].data_mode, 1'b0,
                      vecs[v].exp_words, vecs[v].exp_base);
            @(negedge clk);
            check("idle_busy_after", 64'(busy), 64'd0);
            check("idle_done_once", 64'(done), 64'd0);
        end

        // Abort while index 7 is on offer, coincident with a handshake.
        fill_regs(0);
        @(negedge clk);
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            out_ready = 1'b1;
            n++;
        end while (!(out_valid && out_index == 5'd7) && n < 200);
        check("abort_reached_7", 64'(out_index), 64'd7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rr1", 64'(read_reg_1), 64'd0);
        cnt_v = 0; cnt_d = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            cnt_v += int'(out_valid);
            cnt_d += int'(done);
        end
        check("abort_no_done", 64'(cnt_d), 64'd0);
        check("abort_stays_idle", 64'(cnt_v), 64'd0);
        run_sweep(4'b1111, 1'b0, 1, 1'b0, 32, 49);
        @(negedge clk);

        // Start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-sweep.
        fill_regs(1);
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_index", 64'(out_index), 64'd0);
        check("mid_rst_rr2", 64'(read_reg_2), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(4'b1111, 1'b0, 0, 1'b0, 32, 49);
        @(negedge clk);

        // Start held high: the next sweep starts right after the DONE cycle.
        run_sweep(4'b1111, 1'b0, 0, 1'b1, 32, 49);
        @(negedge clk);
        check("held_idle_gap", 64'(busy), 64'd0);
        @(negedge clk);
        check("held_restart_busy", 64'(busy), 64'd1);
        start = 1'b0;
        @(negedge clk);
        check("held_restart_valid", 64'(out_valid), 64'd1);
        check("held_restart_index", 64'(out_index), 64'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("held_abort_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_register_scanner.md
# mips_register_scanner

Read-side sweep engine for the MIPS register file. On a start request it drives the two register-file read ports (`read_reg_1`, `read_reg_2`) over every register, two per pass, and captures the combinational read data. Each captured word is emitted, in ascending register order, on a valid/ready output stream. It sits beside `mips_registers` as the debug/dump client of its read ports and never touches the write port.

## Interface
Parameters:
- `NUM_REGS`, 32, number of registers swept; must be even, ≤ 2^`ADDR_WIDTH`
- `ADDR_WIDTH`, 5, register index width
- `DATA_WIDTH`, 32, register word width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a sweep; sampled only in IDLE
- `abort`  in  1  cancel a sweep in progress
- `read_reg_1`  out  ADDR_WIDTH  register file read address 1
- `read_reg_2`  out  ADDR_WIDTH  register file read address 2
- `read_data_1`  in  DATA_WIDTH  register file read data 1, combinational from `read_reg_1`
- `read_data_2`  in  DATA_WIDTH  register file read data 2, combinational from `read_reg_2`
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  consumer accepts word
- `out_data`  out  DATA_WIDTH  register contents
- `out_index`  out  ADDR_WIDTH  register number of `out_data`
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at sweep completion
- `checksum`  out  DATA_WIDTH  present only with `SCAN_CHECKSUM_EN`

## Operation
- States: IDLE, READ, SEND_A, SEND_B, DONE. Pair counter `p` runs 0..NUM_REGS/2-1.
- IDLE:
  - `read_reg_1` = 0, `read_reg_2` = 1.
  - `start`=1 → `p`=0, go to READ.
- READ:
  - `read_reg_1` = 2p, `read_reg_2` = 2p+1.
  - `read_data_1`/`read_data_2` are latched into a 2-entry buffer at the end of the cycle.
  - Always go to SEND_A.
- SEND_A:
  - `out_valid`=1, `out_data`=buffer[0], `out_index`=2p.
  - Handshake (`out_valid & out_ready`) → go to SEND_B.
- SEND_B:
  - `out_valid`=1, `out_data`=buffer[1], `out_index`=2p+1.
  - On handshake: if `p`==NUM_REGS/2-1 go to DONE, else `p`++ and go to READ.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `busy` = 1 in READ, SEND_A, SEND_B and DONE.
- While `out_valid`=1 and `out_ready`=0, `out_data`/`out_index` are held stable. `out_valid` never drops without a handshake, except on abort or reset.
- `abort`=1 in any non-IDLE state → IDLE on the next edge:
  - `out_valid` and `busy` drop.
  - No `done` pulse is generated.
  - `abort` takes priority over a coincident handshake.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE → `abort` wins; stay IDLE.
- Register contents are sampled in READ only. Writes to the register file after a pair's READ cycle are not reflected in that pair.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `p`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `busy`=0, `done`=0, `checksum`=0, `read_reg_1`=0, `read_reg_2`=1.
- `start` sampled at edge N → READ during cycle N+1 → first `out_valid` during cycle N+2.
- With `out_ready` held at 1:
  - each pair costs 3 cycles; a full 32-register sweep is 48 cycles;
  - `done` is high in cycle N+49; `busy` is high cycles N+1..N+49.
- Each cycle of `out_ready`=0 while valid adds exactly one cycle of latency.
- `rst_n` low mid-sweep aborts immediately (asynchronously); outputs take their reset values.

## Configuration
- `SCAN_CHECKSUM_EN` defined:
  - `checksum` port exists; it is the XOR of every `out_data` accepted by handshake.
  - Cleared to 0 when `start` is accepted.
  - Final value valid from the `done` cycle until the next accepted `start`.
  - Unchanged by abort.
- Not defined: no `checksum` port and no checksum logic; all other behaviour identical.

## Test plan
- Register model with reg i = i×0x01010101 (reg0 = 0), `out_ready`=1, pulse `start` → 32 words in index order 0..31 with matching data, `done` exactly once in cycle 49 after `start`, `busy` low afterwards.
- Same sweep with `out_ready` toggling 1,0,0,1… → identical word sequence, data/index stable during every stall, no word duplicated or dropped.
- Assert `abort` while `out_index`=7 is pending → `out_valid`=0 next cycle, no `done`; a new `start` then restarts from index 0.
- Assert `rst_n`=0 mid-sweep → all outputs at reset values immediately; `start` after release gives a full 32-word sweep.
- `start` held high throughout a sweep → exactly one sweep per IDLE visit; the second sweep begins the cycle after `done`.
- `SCAN_CHECKSUM_EN` defined, regs 0..31 = 0xE001C000 except reg2 = 0x0000FFFF → `checksum` = 0xE001C000 ^ 0x0000FFFF = 0xE0013FFF at `done`.
